// File: rtl/speicher_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package speicher_pkg;

    typedef enum logic [2:0] {
        LEERLAUF,
        LESE_I,
        LESE_D,
        SCHREIBEN,
        ANTWORT
    } zustand_t;

    localparam logic [31:0] FEHLER_DATEN   = 32'hDEAD_BEEF;
    localparam int          ADR_BREITE_STD = 26;

endpackage

// File: rtl/speicher_zeitwaechter.sv
// Watchdog cycle counter: counts enabled cycles and flags the cycle in which the limit is reached.
module speicher_zeitwaechter #(
    parameter int GRENZE = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic loeschen_i,
    input  logic zaehlen_i,
    output logic abgelaufen_o
);

    localparam int BREITE = (GRENZE > 1) ? $clog2(GRENZE) : 1;

    logic [BREITE-1:0] zaehler_q, zaehler_d;

    // Saturates at the limit so a stalled access cannot wrap back to zero.
    always_comb begin
        zaehler_d = zaehler_q;
        if (loeschen_i)
            zaehler_d = '0;
        else if (zaehlen_i && !abgelaufen_o)
            zaehler_d = zaehler_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            zaehler_q <= '0;
        else
            zaehler_q <= zaehler_d;
    end

    assign abgelaufen_o = zaehlen_i && (zaehler_q == BREITE'(GRENZE - 1));

endmodule

// File: rtl/speicher_arbiter.sv
// Arbitrates one single-port memory between CPU fetch and load/store ports.
// Optional watchdog enabled with macro SPEICHER_TIMEOUT_EN.
module speicher_arbiter
    import speicher_pkg::*;
#(
    parameter int ADR_BREITE     = ADR_BREITE_STD,
    parameter int TIMEOUT_ZYKLEN = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [31:0]           InstruktionAdresse,
    input  logic                  LeseInstruktion,
    input  logic [31:0]           DatenAdresse,
    input  logic [31:0]           DatenRaus,
    input  logic                  LeseDaten,
    input  logic                  SchreibeDaten,
    output logic [31:0]           Instruktion,
    output logic [31:0]           DatenRein,
    output logic                  InstruktionGeladen,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic [ADR_BREITE-1:0] SpeicherAdresse,
    output logic [31:0]           SpeicherSchreibDaten,
    output logic                  SpeicherLesen,
    output logic                  SpeicherSchreiben,
    input  logic [31:0]           SpeicherLeseDaten,
    input  logic                  SpeicherFertig,
    output logic                  Fehler
);

    zustand_t              zustand_q;
    logic [ADR_BREITE-1:0] adresse_q;
    logic [31:0]           schreib_daten_q, instruktion_q, daten_rein_q;
    logic                  lesen_q, schreiben_q, fehler_q;
    logic                  geladen_i_q, geladen_d_q, gespeichert_q;
    logic                  im_zugriff, abgelaufen, zugriff_ende;
    logic [31:0]           lese_wert;
    logic                  unused_bits;

    assign im_zugriff   = (zustand_q == LESE_I) || (zustand_q == LESE_D) || (zustand_q == SCHREIBEN);
    assign zugriff_ende = SpeicherFertig || abgelaufen;
    // A completion in the limit cycle wins over the timeout.
    assign lese_wert    = SpeicherFertig ? SpeicherLeseDaten : FEHLER_DATEN;

`ifdef SPEICHER_TIMEOUT_EN
    speicher_zeitwaechter #(
        .GRENZE(TIMEOUT_ZYKLEN)
    ) u_zeitwaechter (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .loeschen_i  (!im_zugriff),
        .zaehlen_i   (im_zugriff),
        .abgelaufen_o(abgelaufen)
    );
    assign Fehler      = fehler_q;
    assign unused_bits = ^{InstruktionAdresse[31:ADR_BREITE], DatenAdresse[31:ADR_BREITE]};
`else
    assign abgelaufen  = 1'b0;
    assign Fehler      = 1'b0;
    assign unused_bits = ^{InstruktionAdresse[31:ADR_BREITE], DatenAdresse[31:ADR_BREITE],
                           TIMEOUT_ZYKLEN, fehler_q};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand_q       <= LEERLAUF;
            adresse_q       <= '0;
            schreib_daten_q <= '0;
            instruktion_q   <= '0;
            daten_rein_q    <= '0;
            lesen_q         <= 1'b0;
            schreiben_q     <= 1'b0;
            fehler_q        <= 1'b0;
            geladen_i_q     <= 1'b0;
            geladen_d_q     <= 1'b0;
            gespeichert_q   <= 1'b0;
        end else begin
            geladen_i_q   <= 1'b0;
            geladen_d_q   <= 1'b0;
            gespeichert_q <= 1'b0;
            case (zustand_q)
                LEERLAUF: begin
                    if (SchreibeDaten) begin
                        zustand_q       <= SCHREIBEN;
                        schreiben_q     <= 1'b1;
                        adresse_q       <= DatenAdresse[ADR_BREITE-1:0];
                        schreib_daten_q <= DatenRaus;
                    end else if (LeseDaten) begin
                        zustand_q <= LESE_D;
                        lesen_q   <= 1'b1;
                        adresse_q <= DatenAdresse[ADR_BREITE-1:0];
                    end else if (LeseInstruktion) begin
                        zustand_q <= LESE_I;
                        lesen_q   <= 1'b1;
                        adresse_q <= InstruktionAdresse[ADR_BREITE-1:0];
                    end
                end
                LESE_I, LESE_D, SCHREIBEN: begin
                    if (zugriff_ende) begin
                        zustand_q   <= ANTWORT;
                        lesen_q     <= 1'b0;
                        schreiben_q <= 1'b0;
                        if (!SpeicherFertig)
                            fehler_q <= 1'b1;
                        case (zustand_q)
                            LESE_I: begin
                                instruktion_q <= lese_wert;
                                geladen_i_q   <= 1'b1;
                            end
                            LESE_D: begin
                                daten_rein_q <= lese_wert;
                                geladen_d_q  <= 1'b1;
                            end
                            default: gespeichert_q <= 1'b1;
                        endcase
                    end
                end
                // ANTWORT: requests still high from the finished access are ignored here.
                default: zustand_q <= LEERLAUF;
            endcase
        end
    end

    assign Instruktion          = instruktion_q;
    assign DatenRein            = daten_rein_q;
    assign InstruktionGeladen   = geladen_i_q;
    assign DatenGeladen         = geladen_d_q;
    assign DatenGespeichert     = gespeichert_q;
    assign SpeicherAdresse      = adresse_q;
    assign SpeicherSchreibDaten = schreib_daten_q;
    assign SpeicherLesen        = lesen_q;
    assign SpeicherSchreiben    = schreiben_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Self-checking bench for speicher_arbiter: directed and random CPU traffic against a memory model.
module tb_speicher_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] InstruktionAdresse, DatenAdresse, DatenRaus;
    logic        LeseInstruktion, LeseDaten, SchreibeDaten;
    logic [31:0] Instruktion, DatenRein;
    logic        InstruktionGeladen, DatenGeladen, DatenGespeichert;
    logic [25:0] SpeicherAdresse;
    logic [31:0] SpeicherSchreibDaten, SpeicherLeseDaten;
    logic        SpeicherLesen, SpeicherSchreiben, SpeicherFertig, Fehler;

    speicher_arbiter #(.ADR_BREITE(26), .TIMEOUT_ZYKLEN(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .InstruktionAdresse(InstruktionAdresse), .LeseInstruktion(LeseInstruktion),
        .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus),
        .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
        .Instruktion(Instruktion), .DatenRein(DatenRein),
        .InstruktionGeladen(InstruktionGeladen), .DatenGeladen(DatenGeladen),
        .DatenGespeichert(DatenGespeichert),
        .SpeicherAdresse(SpeicherAdresse), .SpeicherSchreibDaten(SpeicherSchreibDaten),
        .SpeicherLesen(SpeicherLesen), .SpeicherSchreiben(SpeicherSchreiben),
        .SpeicherLeseDaten(SpeicherLeseDaten), .SpeicherFertig(SpeicherFertig),
        .Fehler(Fehler)
    );

    always #5 Clock = ~Clock;

    int n_total = 0, n_pass = 0, n_fail = 0;

    // Memory environment and reference memory, both indexed by the truncated word address.
    logic [31:0] mem_dut [logic [25:0]];
    logic [31:0] ref_mem [logic [25:0]];
    int  mem_lat = 0, warte = 0, n_zugriffe = 0;
    bit  mem_stumm = 0, fertig_spuk = 0;

    // Monitor counters.
    int  n_puls_i = 0, n_puls_d = 0, n_puls_s = 0, n_starts = 0, n_beide = 0;
    int  strobe_len = 0, luecke = 0, min_luecke = 1000;
    bit  strobe_alt = 0;

    // Expectations.
    int  exp_i = 0, exp_d = 0, exp_s = 0, exp_zugriffe = 0, exp_starts = 0;
    logic [31:0] soll_instr = '0, soll_daten = '0;

    function automatic logic [31:0] init_wort(input logic [25:0] a);
        return {6'h2A, a} ^ 32'h0F0F_0F0F;
    endfunction

    function automatic logic [31:0] ref_lesen(input logic [25:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_wort(a);
    endfunction

    function automatic logic [127:0] alle_ausgaenge();
        return {Instruktion, DatenRein, InstruktionGeladen, DatenGeladen, DatenGespeichert,
                SpeicherAdresse, SpeicherSchreibDaten, SpeicherLesen, SpeicherSchreiben, Fehler};
    endfunction

    task automatic check(input string tag, input logic [127:0] beob, input logic [127:0] soll);
        n_total++;
        assert (beob === soll) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, beob, soll);
        end
    endtask

    // Memory responder: answers a strobe after mem_lat extra cycles unless muted.
    always @(negedge Clock) begin
        SpeicherLeseDaten = $urandom();
        SpeicherFertig    = 1'b0;
        if (Reset || !(SpeicherLesen || SpeicherSchreiben)) begin
            warte          = mem_lat;
            SpeicherFertig = fertig_spuk && !Reset;
        end else if (mem_stumm) begin
            warte = mem_lat;
        end else if (warte > 0) begin
            warte--;
        end else begin
            SpeicherFertig = 1'b1;
            n_zugriffe++;
            if (SpeicherSchreiben)
                mem_dut[SpeicherAdresse] = SpeicherSchreibDaten;
            else
                SpeicherLeseDaten = mem_dut.exists(SpeicherAdresse) ? mem_dut[SpeicherAdresse]
                                                                     : init_wort(SpeicherAdresse);
        end
    end

    // Pulse, strobe-run and idle-gap monitor.
    always @(negedge Clock) begin
        bit strobe;
        if (InstruktionGeladen) n_puls_i++;
        if (DatenGeladen)       n_puls_d++;
        if (DatenGespeichert)   n_puls_s++;
        if (SpeicherLesen && SpeicherSchreiben) n_beide++;
        strobe = SpeicherLesen || SpeicherSchreiben;
        if (strobe) begin
            if (!strobe_alt) begin
                n_starts++;
                if (n_starts > 1 && luecke < min_luecke) min_luecke = luecke;
                strobe_len = 1;
            end else begin
                strobe_len++;
            end
            luecke = 0;
        end else begin
            luecke++;
        end
        strobe_alt = strobe;
    end

    task automatic lade(input logic [25:0] a, input logic [31:0] w);
        mem_dut[a] = w;
        ref_mem[a] = w;
    endtask

    task automatic warte_puls(input int art, output int zyklen);
        bit gesehen;
        gesehen = 0;
        zyklen  = 0;
        while (!gesehen && zyklen < 200) begin
            @(negedge Clock);
            zyklen++;
            case (art)
                0:       gesehen = InstruktionGeladen;
                1:       gesehen = DatenGeladen;
                default: gesehen = DatenGespeichert;
            endcase
        end
    endtask

    // One CPU access: art 0 = fetch, 1 = load, 2 = store. Request held through the ANTWORT cycle.
    task automatic zugriff(input int art, input logic [31:0] adr, input logic [31:0] wdat, input int lat);
        int          zyklen;
        logic [25:0] wa;
        wa      = adr[25:0];
        mem_lat = lat;
        @(negedge Clock);
        case (art)
            0: begin InstruktionAdresse = adr; LeseInstruktion = 1'b1; end
            1: begin DatenAdresse = adr; LeseDaten = 1'b1; end
            default: begin DatenAdresse = adr; DatenRaus = wdat; SchreibeDaten = 1'b1; end
        endcase
        warte_puls(art, zyklen);
        check($sformatf("latenz_art%0d", art), zyklen, lat + 2);
        check($sformatf("adresse_art%0d", art), SpeicherAdresse, wa);
        case (art)
            0: begin
                soll_instr = ref_lesen(wa);
                check("instruktion", Instruktion, soll_instr);
                exp_i++;
            end
            1: begin
                soll_daten = ref_lesen(wa);
                check("daten_rein", DatenRein, soll_daten);
                exp_d++;
            end
            default: begin
                check("schreib_daten", SpeicherSchreibDaten, wdat);
                ref_mem[wa] = wdat;
                exp_s++;
            end
        endcase
        exp_zugriffe++;
        exp_starts++;
        @(posedge Clock);
        #1;
        LeseInstruktion = 1'b0;
        LeseDaten       = 1'b0;
        SchreibeDaten   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int z;
        Reset = 1'b1;
        InstruktionAdresse = '0; DatenAdresse = '0; DatenRaus = '0;
        LeseInstruktion = 1'b0; LeseDaten = 1'b0; SchreibeDaten = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_ausgaenge", alle_ausgaenge(), '0);
        Reset = 1'b0;

        // Fetch at 0x40, memory answers after 3 wait cycles.
        lade(26'h40, 32'h1234_5678);
        zugriff(0, 32'h0000_0040, '0, 3);
        check("fetch_wert_0x40", Instruktion, 32'h1234_5678);

        // Minimum latency load; upper address bits must be dropped.
        zugriff(1, 32'hFC00_0080, '0, 0);

        // Load and fetch raised together: load first, then fetch.
        @(negedge Clock);
        mem_lat = 1;
        DatenAdresse = 32'h0000_02C0; InstruktionAdresse = 32'h0000_02C4;
        LeseDaten = 1'b1; LeseInstruktion = 1'b1;
        warte_puls(1, z);
        check("doppel_d_zyklen", z, 3);
        soll_daten = ref_lesen(26'h2C0);
        check("doppel_d_wert", DatenRein, soll_daten);
        check("doppel_i_noch_alt", Instruktion, soll_instr);
        @(posedge Clock); #1;
        LeseDaten = 1'b0;
        warte_puls(0, z);
        check("doppel_i_zyklen", z, 4);
        soll_instr = ref_lesen(26'h2C4);
        check("doppel_i_wert", Instruktion, soll_instr);
        @(posedge Clock); #1;
        LeseInstruktion = 1'b0;
        exp_d++; exp_i++; exp_zugriffe += 2; exp_starts += 2;

        // Store with a concurrent load: only the store is served.
        @(negedge Clock);
        mem_lat = 2;
        DatenAdresse = 32'h0000_0100; DatenRaus = 32'hCAFE_0001;
        SchreibeDaten = 1'b1; LeseDaten = 1'b1;
        warte_puls(2, z);
        check("st_ld_zyklen", z, 4);
        check("st_ld_adresse", SpeicherAdresse, 26'h100);
        check("st_ld_wdat", SpeicherSchreibDaten, 32'hCAFE_0001);
        check("st_ld_rein_unveraendert", DatenRein, soll_daten);
        @(posedge Clock); #1;
        SchreibeDaten = 1'b0; LeseDaten = 1'b0;
        ref_mem[26'h100] = 32'hCAFE_0001;
        exp_s++; exp_zugriffe++; exp_starts++;

        // The stored word must come back from memory.
        zugriff(0, 32'h0000_0100, '0, 1);

        // Completion strobe while idle must be ignored.
        fertig_spuk = 1'b1;
        repeat (3) @(negedge Clock);
        fertig_spuk = 1'b0;
        @(negedge Clock);
        check("spuk_instruktion", Instruktion, soll_instr);
        check("spuk_daten", DatenRein, soll_daten);

        // Reset in the middle of a load.
        @(negedge Clock);
        mem_stumm = 1'b1;
        DatenAdresse = 32'h0000_0200; LeseDaten = 1'b1;
        z = 0;
        while (!SpeicherLesen && z < 20) begin
            @(negedge Clock);
            z++;
        end
        check("rst_strobe_an", SpeicherLesen, 1'b1);
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("rst_strobe_ab", SpeicherLesen, 1'b0);
        check("rst_alle_null", alle_ausgaenge(), '0);
        LeseDaten = 1'b0; mem_stumm = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        exp_starts++;
        soll_instr = '0; soll_daten = '0;
        repeat (2) @(negedge Clock);
        zugriff(1, 32'h0000_0200, '0, 1);

        // Random traffic over a small address pool with random upper bits.
        for (int i = 0; i < 30; i++) begin
            int          art;
            logic [31:0] adr;
            art = $urandom_range(0, 2);
            adr = ($urandom() & 32'hFC00_0000) | (32'h100 + 4 * $urandom_range(0, 7));
            zugriff(art, adr, $urandom(), $urandom_range(0, 4));
        end

`ifdef SPEICHER_TIMEOUT_EN
        // Memory never answers a load: abort after 8 strobe cycles.
        @(negedge Clock);
        mem_stumm = 1'b1;
        DatenAdresse = 32'h0000_0300; LeseDaten = 1'b1;
        warte_puls(1, z);
        check("to_zyklen", z, 9);
        check("to_strobe_laenge", strobe_len, 8);
        check("to_daten", DatenRein, 32'hDEAD_BEEF);
        check("to_fehler", Fehler, 1'b1);
        @(posedge Clock); #1;
        LeseDaten = 1'b0; mem_stumm = 1'b0;
        exp_d++; exp_starts++;
        zugriff(0, 32'h0000_0040, '0, 1);
        check("to_fehler_klebt", Fehler, 1'b1);
`else
        check("fehler_aus", Fehler, 1'b0);
`endif

        repeat (2) @(posedge Clock);
        #1;
        check("anzahl_puls_i", n_puls_i, exp_i);
        check("anzahl_puls_d", n_puls_d, exp_d);
        check("anzahl_puls_s", n_puls_s, exp_s);
        check("anzahl_zugriffe", n_zugriffe, exp_zugriffe);
        check("anzahl_strobe_starts", n_starts, exp_starts);
        check("nie_beide_strobes", n_beide, 0);
        check("luecke_zwischen_strobes", min_luecke >= 1, 1'b1);

        Reset = 1'b1;
        #3;
        check("fehler_nach_reset", Fehler, 1'b0);
        Reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
